frv_core_mem_arbiter: RTL

//  Shares one 32-bit memory port between instruction fetch (i_*) and data

---
 rtl/frv_core_mem_arbiter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/frv_core_mem_arbiter.sv
// frv_core_mem_arbiter
// Shares one 32-bit memory port between instruction fetch (i_*) and data
// access (d_*). Data has priority. Grants are held for a whole transaction.
// Optional fetch anti-starvation is enabled by defining FRV_MEM_ARB_FAIR_EN.
module frv_core_mem_arbiter #(
    parameter int unsigned ARB_STARVE_LIMIT = 4,
    parameter int unsigned ARB_CNT_W        = 3
) (
    input  logic        g_clk,
    input  logic        g_resetn,

    input  logic        i_cen,
    input  logic        i_wen,
    input  logic [3:0]  i_strb,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        i_stall,
    output logic        i_error,
    output logic [31:0] i_rdata,

    input  logic        d_cen,
    input  logic        d_wen,
    input  logic [3:0]  d_strb,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_stall,
    output logic        d_error,
    output logic [31:0] d_rdata,

    output logic        m_cen,
    output logic        m_wen,
    output logic [3:0]  m_strb,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic        m_stall,
    input  logic        m_error,
    input  logic [31:0] m_rdata
);

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_GNT_I,
        ARB_GNT_D
    } arb_state_t;

    arb_state_t state;
    arb_state_t state_nxt;

    logic gnt_i;
    logic gnt_d;
    logic m_done;
    logic arb_en;
    logic force_i;

    assign gnt_i  = (state == ARB_GNT_I);
    assign gnt_d  = (state == ARB_GNT_D);
    assign m_done = m_cen && !m_stall;

    // Re-arbitrate when idle, when the current transaction completes, or
    // when the granted requester abandons its request.
    assign arb_en = (state == ARB_IDLE) || m_done ||
                    (gnt_i && !i_cen) || (gnt_d && !d_cen);

    // Memory-side mux: all m_* outputs follow the granted requester.
    always_comb begin
        m_cen   = 1'b0;
        m_wen   = 1'b0;
        m_strb  = '0;
        m_addr  = '0;
        m_wdata = '0;
        case (state)
            ARB_GNT_I: begin
                m_cen   = i_cen;
                m_wen   = i_wen;
                m_strb  = i_strb;
                m_addr  = i_addr;
                m_wdata = i_wdata;
            end
            ARB_GNT_D: begin
                m_cen   = d_cen;
                m_wen   = d_wen;
                m_strb  = d_strb;
                m_addr  = d_addr;
                m_wdata = d_wdata;
            end
            default: ;
        endcase
    end

    assign i_stall = !gnt_i || m_stall;
    assign d_stall = !gnt_d || m_stall;
    assign i_error = gnt_i && m_done && m_error;
    assign d_error = gnt_d && m_done && m_error;
    assign i_rdata = m_rdata;
    assign d_rdata = m_rdata;

    // Next-state: forced fetch grant, else data, else fetch, else idle.
    always_comb begin
        state_nxt = state;
        if (arb_en) begin
            if (force_i)    state_nxt = ARB_GNT_I;
            else if (d_cen) state_nxt = ARB_GNT_D;
            else if (i_cen) state_nxt = ARB_GNT_I;
            else            state_nxt = ARB_IDLE;
        end
    end

    // Grant state register.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) state <= ARB_IDLE;
        else           state <= state_nxt;
    end

`ifdef FRV_MEM_ARB_FAIR_EN
    logic [ARB_CNT_W-1:0] starve_cnt;
    logic                 d_done_iw;

    assign d_done_iw = gnt_d && m_done && i_cen;

    // The completion that brings the count to the limit already hands the
    // next grant to fetch, so exactly LIMIT data transfers pass it by.
    assign force_i = i_cen &&
                     ((starve_cnt == ARB_CNT_W'(ARB_STARVE_LIMIT)) ||
                      (d_done_iw && (starve_cnt == ARB_CNT_W'(ARB_STARVE_LIMIT - 1))));

    // Count data completions that overtook a waiting fetch.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            starve_cnt <= '0;
        end else if (!i_cen || gnt_i || (state_nxt == ARB_GNT_I)) begin
            starve_cnt <= '0;
        end else if (d_done_iw && (starve_cnt != ARB_CNT_W'(ARB_STARVE_LIMIT))) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end
`else
    logic [ARB_CNT_W-1:0] unused_fair_cfg;

    assign force_i         = 1'b0;
    assign unused_fair_cfg = ARB_CNT_W'(ARB_STARVE_LIMIT);
`endif

endmodule
